// File: rtl/byte_serial_tx_if.sv
// Handshake and serial-line bundle for the byte serial transmitter.
// The master side supplies the byte and the load request.
// The slave side (the transmitter) returns ready, the serial line and the frame status.
interface byte_serial_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] d;
  logic             load;
  logic             ready;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output d, load,
    input  ready, sout, busy, done
  );

  modport slave (
    input  d, load,
    output ready, sout, busy, done
  );
endinterface

// File: rtl/byte_serial_tx.sv
// Byte serial transmitter.
// Sends one frame for each accepted byte: a start bit, then the data bits LSB
// first, then a stop bit. Each bit is held on sout for DIV clock cycles.
// Every output comes from registered state, so no input reaches an output
// without passing through a register first.
module byte_serial_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input logic            clk,
  input logic            reset,
  byte_serial_tx_if.slave bus
);

  localparam int DW = $clog2(DIV + 1);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [DW-1:0]    r_divCnt;
  logic [BW-1:0]    r_bitCnt;
  logic [WIDTH-1:0] r_shreg;
  logic             r_done;
  logic             w_bitEnd;
  logic             w_accept;
  logic             w_sout;

  // Flag the last cycle of the current bit slot and a load accepted while idle.
  always_comb begin
    w_bitEnd = 1'b0;
    w_accept = 1'b0;
    w_bitEnd = (r_state != IDLE) && (r_divCnt == DIV_LAST);
    w_accept = (r_state == IDLE) && bus.load;
  end

  // Next-state decode for the frame sequence.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_nextState = START;
      START: if (w_bitEnd) w_nextState = DATA;
      DATA:  if (w_bitEnd && (r_bitCnt == BIT_LAST)) w_nextState = STOP;
      STOP:  if (w_bitEnd) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State register, bit timing counters, shift register and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_divCnt <= '0;
      r_bitCnt <= '0;
      r_shreg  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_done  <= (r_state == STOP) && w_bitEnd;
      if (w_accept) begin
        r_shreg  <= bus.d;
        r_divCnt <= '0;
        r_bitCnt <= '0;
      end else if (r_state != IDLE) begin
        if (w_bitEnd) begin
          r_divCnt <= '0;
          if (r_state == DATA) begin
            r_shreg  <= r_shreg >> 1;
            r_bitCnt <= (r_bitCnt == BIT_LAST) ? '0 : r_bitCnt + 1'b1;
          end
        end else begin
          r_divCnt <= r_divCnt + 1'b1;
        end
      end
    end
  end

  // Serial line level decoded from the registered state and shift register.
  always_comb begin
    w_sout = 1'b1;
    case (r_state)
      START:   w_sout = 1'b0;
      DATA:    w_sout = r_shreg[0];
      default: w_sout = 1'b1;
    endcase
  end

  assign bus.sout  = w_sout;
  assign bus.ready = (r_state == IDLE);
  assign bus.busy  = (r_state != IDLE);
  assign bus.done  = r_done;

endmodule

// File: tb/tb_byte_serial_tx.sv
// Directed testbench for byte_serial_tx.
// One transmitter runs with DIV=4 and a second with DIV=1; both are 8 bits wide.
module tb_byte_serial_tx;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  byte_serial_tx_if #(.WIDTH(8)) bus4 ();
  byte_serial_tx_if #(.WIDTH(8)) bus1 ();

  byte_serial_tx #(.WIDTH(8), .DIV(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  byte_serial_tx #(.WIDTH(8), .DIV(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance past the next rising edge so outputs are sampled clear of the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle4(input string tag);
    checkOutput({tag, " sout"},  {7'd0, bus4.sout},  8'd1);
    checkOutput({tag, " ready"}, {7'd0, bus4.ready}, 8'd1);
    checkOutput({tag, " busy"},  {7'd0, bus4.busy},  8'd0);
    checkOutput({tag, " done"},  {7'd0, bus4.done},  8'd0);
  endtask

  // Expected line level for one slot of a frame: start, eight data bits, stop.
  function automatic logic slotBit(input logic [7:0] val, input int slot);
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return val[slot-1];
  endfunction

  // Called just after the accepting edge; walks the 40 frame cycles and,
  // unless aborted early, checks the done pulse at the end. With disturb set
  // d is scrambled every cycle and load is pulsed once mid-frame.
  task automatic applyStimulus(input logic [7:0] val, input bit disturb, input int abortAt);
    for (int c = 0; c < 40; c++) begin
      if (c == abortAt) return;
      checkOutput($sformatf("frame %0h cyc %0d sout", val, c), {7'd0, bus4.sout}, {7'd0, slotBit(val, c / 4)});
      checkOutput($sformatf("frame %0h cyc %0d busy", val, c), {7'd0, bus4.busy}, 8'd1);
      checkOutput($sformatf("frame %0h cyc %0d done", val, c), {7'd0, bus4.done}, 8'd0);
      if (disturb) begin
        bus4.d    = 8'($urandom);
        bus4.load = (c == 12);
      end
      tick();
    end
    checkOutput($sformatf("frame %0h end done", val),  {7'd0, bus4.done},  8'd1);
    checkOutput($sformatf("frame %0h end ready", val), {7'd0, bus4.ready}, 8'd1);
    checkOutput($sformatf("frame %0h end busy", val),  {7'd0, bus4.busy},  8'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus4.d    = 8'h00;
    bus4.load = 1'b0;
    bus1.d    = 8'h00;
    bus1.load = 1'b0;

    // Test 1: reset for three cycles, then ten quiet idle cycles.
    tick(); tick(); tick();
    reset = 1'b0;
    checkIdle4("reset");
    checkOutput("reset div1 sout",  {7'd0, bus1.sout},  8'd1);
    checkOutput("reset div1 ready", {7'd0, bus1.ready}, 8'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkIdle4($sformatf("idle %0d", i));
    end

    // Test 2: single frame for A5 from a one-cycle load pulse.
    $display("[TB] frame A5");
    bus4.d    = 8'hA5;
    bus4.load = 1'b1;
    tick();
    bus4.load = 1'b0;
    applyStimulus(8'hA5, 1'b0, -1);
    tick();
    checkIdle4("after A5");

    // Test 3: load held high across the done cycle gives back-to-back frames.
    $display("[TB] back-to-back 3C then C3");
    bus4.d    = 8'h3C;
    bus4.load = 1'b1;
    tick();
    bus4.d    = 8'hC3;
    applyStimulus(8'h3C, 1'b0, -1);
    tick();
    bus4.load = 1'b0;
    applyStimulus(8'hC3, 1'b0, -1);
    tick();
    checkIdle4("after C3");

    // Test 4: a load and d changes during a busy frame are ignored.
    $display("[TB] frame FF with disturbance");
    bus4.d    = 8'hFF;
    bus4.load = 1'b1;
    tick();
    bus4.load = 1'b0;
    applyStimulus(8'hFF, 1'b1, -1);
    bus4.load = 1'b0;
    bus4.d    = 8'h00;
    for (int i = 0; i < 45; i++) begin
      tick();
      checkIdle4($sformatf("after FF %0d", i));
    end

    // Test 5: reset mid-frame aborts without a done pulse; the next frame is clean.
    $display("[TB] abort 5A then frame 81");
    bus4.d    = 8'h5A;
    bus4.load = 1'b1;
    tick();
    bus4.load = 1'b0;
    applyStimulus(8'h5A, 1'b0, 17);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkIdle4("abort");
    for (int i = 0; i < 45; i++) begin
      tick();
      checkIdle4($sformatf("post abort %0d", i));
    end
    bus4.d    = 8'h81;
    bus4.load = 1'b1;
    tick();
    bus4.load = 1'b0;
    applyStimulus(8'h81, 1'b0, -1);

    // Test 6: DIV=1 frame for 01, one cycle per bit.
    $display("[TB] DIV=1 frame 01");
    bus1.d    = 8'h01;
    bus1.load = 1'b1;
    tick();
    bus1.load = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checkOutput($sformatf("div1 cyc %0d sout", c), {7'd0, bus1.sout}, {7'd0, slotBit(8'h01, c)});
      checkOutput($sformatf("div1 cyc %0d done", c), {7'd0, bus1.done}, 8'd0);
      checkOutput($sformatf("div1 cyc %0d busy", c), {7'd0, bus1.busy}, 8'd1);
      tick();
    end
    checkOutput("div1 end done",  {7'd0, bus1.done},  8'd1);
    checkOutput("div1 end ready", {7'd0, bus1.ready}, 8'd1);
    tick();
    checkOutput("div1 after done", {7'd0, bus1.done}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
